// File: rtl/dected_pkg.sv
// -----------------------------------------------------------------------------
// dected_pkg
// Shared definitions for the DEC-TED load-path checker: GF(2^6) arithmetic
// (primitive polynomial x^6+x+1), the alpha power table and the parity-check
// column function h(j) of the extended binary BCH code over 45 positions.
// -----------------------------------------------------------------------------
package dected_pkg;

    localparam int NUM_POS = 45;  // 32 data + 13 check positions
    localparam int DATA_W  = 32;
    localparam int CHK_W   = 13;  // {P, S3[5:0], S1[5:0]}

    localparam logic [6:0] GF_POLY = 7'b1000011;  // x^6 + x + 1

    typedef logic [CHK_W-1:0] syn_t;

    // alpha^k for k = 0..62 (alpha^63 wraps back to 1)
    localparam logic [5:0] ALPHA [63] = '{
        6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h03, 6'h06,
        6'h0C, 6'h18, 6'h30, 6'h23, 6'h05, 6'h0A, 6'h14, 6'h28,
        6'h13, 6'h26, 6'h0F, 6'h1E, 6'h3C, 6'h3B, 6'h35, 6'h29,
        6'h11, 6'h22, 6'h07, 6'h0E, 6'h1C, 6'h38, 6'h33, 6'h25,
        6'h09, 6'h12, 6'h24, 6'h0B, 6'h16, 6'h2C, 6'h1B, 6'h36,
        6'h2F, 6'h1D, 6'h3A, 6'h37, 6'h2D, 6'h19, 6'h32, 6'h27,
        6'h0D, 6'h1A, 6'h34, 6'h2B, 6'h15, 6'h2A, 6'h17, 6'h2E,
        6'h1F, 6'h3E, 6'h3F, 6'h3D, 6'h39, 6'h31, 6'h21
    };

    // Shift-and-add multiply in GF(2^6)
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] acc;
        logic [5:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[4:0], 1'b0} ^ (sh[5] ? GF_POLY[5:0] : 6'h00);
        end
        return acc;
    endfunction

    // Column of position j: {1, alpha^(3j), alpha^j}. alpha^(3j) is formed as
    // the cube of alpha^j, which equals the table entry at index 3j mod 63.
    function automatic syn_t h_col(input int j);
        logic [5:0] a1;
        logic [5:0] a3;
        a1 = ALPHA[6'(j % 63)];
        a3 = gf_mul(gf_mul(a1, a1), a1);
        return {1'b1, a3, a1};
    endfunction

endpackage

// File: rtl/dected_syndrome.sv
// -----------------------------------------------------------------------------
// dected_syndrome
// Combinational syndrome generator: XOR of h(j) over every set bit of the
// 45-bit received word {chk, data}, where data[i] is position i+1 and
// chk[k] is position 33+k.
// Ports:
//   data     in  32  received data word
//   chk      in  13  received check bits (parity[12:0])
//   syndrome out 13  {P, S3, S1}
// -----------------------------------------------------------------------------
module dected_syndrome
    import dected_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W-1:0]  chk,
    output syn_t              syndrome
);

    logic [NUM_POS-1:0] word;
    syn_t               hcol [NUM_POS];

    assign word = {chk, data};

    // Columns are elaboration-time constants
    for (genvar g = 0; g < NUM_POS; g++) begin : g_col
        assign hcol[g] = h_col(g + 1);
    end

    always_comb begin
        syndrome = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (word[i]) syndrome = syndrome ^ hcol[i];
        end
    end

endmodule

// File: rtl/load_module.sv
// -----------------------------------------------------------------------------
// load_module
// DEC-TED checker on the load path. Corrects up to two flipped bits of the
// 45-bit codeword (32 data + 13 check) and flags three or more as
// uncorrectable. One cycle of latency, one word per cycle.
// Ports:
//   clk            in   1  rising-edge clock
//   rst_n          in   1  asynchronous active-low reset
//   data           in  32  received data word
//   parity         in  16  received check bits; [15:13] ignored
//   corrected_data out 32  corrected data (raw data when uncorrectable)
//   triple_error   out  1  uncorrectable-error flag
// -----------------------------------------------------------------------------
module load_module
    import dected_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PAR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  parity,
    output logic [DATA_W-1:0] corrected_data,
    output logic              triple_error
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    syn_t              syn_p0;
    syn_t              hcol [1:NUM_POS];
    logic              single_hit_p0;
    logic              pair_hit_p0;
    logic [DATA_W-1:0] single_mask_p0;
    logic [DATA_W-1:0] pair_mask_p0;
    logic [DATA_W-1:0] flip_mask_p0;
    logic              triple_p0;
    logic              unused_parity;

    assign unused_parity = ^parity[PAR_W-1:CHK_W];

    for (genvar g = 1; g <= NUM_POS; g++) begin : g_col
        assign hcol[g] = h_col(g);
    end

    dected_syndrome u_syndrome (
        .data     (data),
        .chk      (parity[CHK_W-1:0]),
        .syndrome (syn_p0)
    );

    // Stage 0: classification and flip-mask generation.
    // Every single and pair compare runs in parallel; hits are OR-reduced into
    // one-hot data masks. Shifting ONE by a position above DATA_W yields zero,
    // so check-bit positions drop out of the masks on their own. A column
    // always has P=1 and a pair sum always has P=0, so the matches themselves
    // encode the parity condition.
    always_comb begin
        single_hit_p0  = 1'b0;
        single_mask_p0 = '0;
        for (int j = 1; j <= NUM_POS; j++) begin
            if (syn_p0 == hcol[j]) begin
                single_hit_p0  = 1'b1;
                single_mask_p0 = single_mask_p0 | (ONE << (j - 1));
            end
        end
    end

    always_comb begin
        pair_hit_p0  = 1'b0;
        pair_mask_p0 = '0;
        for (int a = 1; a < NUM_POS; a++) begin
            for (int b = a + 1; b <= NUM_POS; b++) begin
                if (syn_p0 == (hcol[a] ^ hcol[b])) begin
                    pair_hit_p0  = 1'b1;
                    pair_mask_p0 = pair_mask_p0 | (ONE << (a - 1)) | (ONE << (b - 1));
                end
            end
        end
    end

    always_comb begin
        flip_mask_p0 = '0;
        triple_p0    = 1'b0;
        if (syn_p0 != '0) begin
            if (single_hit_p0) begin
                flip_mask_p0 = single_mask_p0;
            end else if (pair_hit_p0) begin
                flip_mask_p0 = pair_mask_p0;
            end else begin
                triple_p0 = 1'b1;
            end
        end
    end

    // Stage 1: output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corrected_data <= '0;
            triple_error   <= 1'b0;
        end else begin
            corrected_data <= data ^ flip_mask_p0;
            triple_error   <= triple_p0;
        end
    end

endmodule

// File: tb/tb_load_module.sv
module tb_load_module;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [15:0] parity;
    logic [31:0] corrected_data;
    logic        triple_error;

    int n_cmp = 0;
    int n_mis = 0;

    logic [12:0] cols [1:45];

    load_module dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data           (data),
        .parity         (parity),
        .corrected_data (corrected_data),
        .triple_error   (triple_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // GF(64) multiply by polynomial long multiplication modulo x^6+x+1
    function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] prod;
        prod = '0;
        for (int i = 0; i < 6; i++)
            if (b[i]) prod = prod ^ (11'(a) << i);
        for (int k = 10; k >= 6; k--)
            if (prod[k]) prod = prod ^ (11'h043 << (k - 6));
        return prod[5:0];
    endfunction

    function automatic logic [12:0] make_col(input int j);
        logic [5:0] p;
        p = 6'h01;
        for (int k = 0; k < j; k++) p = gmul(p, 6'h02);
        return {1'b1, gmul(gmul(p, p), p), p};
    endfunction

    // Reference decoder straight from the classification rules
    task automatic ref_decode(input logic [31:0] d, input logic [15:0] pr,
                              output logic [31:0] od, output logic ot);
        logic [45:1] cw;
        logic [12:0] s;
        bit          done;
        for (int j = 1; j <= 45; j++) cw[j] = (j <= 32) ? d[j-1] : pr[j-33];
        s = '0;
        for (int j = 1; j <= 45; j++) if (cw[j]) s = s ^ cols[j];
        done = 1'b0;
        ot   = 1'b0;
        if (s == 13'd0) done = 1'b1;
        for (int j = 1; j <= 45 && !done; j++)
            if (s == cols[j]) begin cw[j] = ~cw[j]; done = 1'b1; end
        for (int a = 1; a <= 45 && !done; a++)
            for (int b = a + 1; b <= 45 && !done; b++)
                if (s == (cols[a] ^ cols[b])) begin
                    cw[a] = ~cw[a]; cw[b] = ~cw[b]; done = 1'b1;
                end
        if (!done) begin
            ot = 1'b1;
            od = d;
        end else begin
            od = cw[32:1];
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [15:0] p);
        @(negedge clk);
        data   = d;
        parity = p;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] ed, input logic et);
        @(posedge clk);
        #1;
        check_val({tag, "_data"}, corrected_data, ed);
        check_val({tag, "_flag"}, {31'b0, triple_error}, {31'b0, et});
    endtask

    task automatic run_word(input string tag, input logic [31:0] d, input logic [15:0] p,
                            input logic [31:0] ed, input logic et);
        drive(d, p);
        expect_out(tag, ed, et);
    endtask

    initial begin
        logic [31:0] ed;
        logic        et;
        logic [45:1] e;
        int          w;
        int          pos;

        for (int j = 1; j <= 45; j++) cols[j] = make_col(j);

        rst_n  = 1'b1;
        data   = 32'h7;
        parity = 16'h0;

        // Let registers pick up a non-zero value, then reset asynchronously
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_data", corrected_data, 32'h0);
        check_val("rst_async_flag", {31'b0, triple_error}, 32'h0);
        @(negedge clk);
        data   = $urandom;
        parity = 16'($urandom);
        @(posedge clk);
        #1;
        check_val("rst_hold_data", corrected_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_release_data", corrected_data, 32'h0);
        check_val("rst_release_flag", {31'b0, triple_error}, 32'h0);

        // Directed patterns on the all-zero codeword
        run_word("single_b0",  32'h1, 16'h0, 32'h0, 1'b0);
        run_word("single_b1",  32'h2, 16'h0, 32'h0, 1'b0);
        run_word("single_b2",  32'h4, 16'h0, 32'h0, 1'b0);
        run_word("double_5",   32'h5, 16'h0, 32'h0, 1'b0);
        run_word("double_3",   32'h3, 16'h0, 32'h0, 1'b0);
        run_word("triple_7",   32'h7, 16'h0, 32'h7, 1'b1);
        run_word("par_single", 32'h0, 16'h0001, 32'h0, 1'b0);
        run_word("par_double", 32'h0, 16'h0003, 32'h0, 1'b0);
        run_word("par_ignored",32'h0, 16'hE000, 32'h0, 1'b0);
        run_word("mix_data_par",32'h80000000, 16'h1000, 32'h0, 1'b0);

        // Back-to-back on consecutive cycles
        run_word("b2b_clean",  32'h0,        16'h0, 32'h0, 1'b0);
        run_word("b2b_double", 32'h80000001, 16'h0, 32'h0, 1'b0);
        run_word("b2b_triple", 32'h7,        16'h0, 32'h7, 1'b1);

        // Random error injection of weight 0..3 on the zero codeword
        for (int n = 0; n < 300; n++) begin
            e = '0;
            w = int'($urandom_range(0, 3));
            for (int k = 0; k < w; k++) begin
                do pos = int'($urandom_range(1, 45)); while (e[pos]);
                e[pos] = 1'b1;
            end
            run_word($sformatf("inj_w%0d", w), e[32:1], {3'($urandom), e[45:33]},
                     (w == 3) ? e[32:1] : 32'h0, (w == 3));
        end

        // Arbitrary random words against the reference decoder
        for (int n = 0; n < 150; n++) begin
            logic [31:0] d;
            logic [15:0] p;
            d = $urandom;
            p = 16'($urandom);
            if (n % 3 == 0) begin
                // sparse words exercise the single/double paths more often
                d = d & $urandom & $urandom & $urandom;
                p = p & 16'($urandom) & 16'($urandom);
            end
            ref_decode(d, p, ed, et);
            run_word("rand", d, p, ed, et);
        end

        // Reset in the middle of the stream discards the in-flight word
        drive(32'h7, 16'h0);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_mid_data", corrected_data, 32'h0);
        check_val("rst_mid_flag", {31'b0, triple_error}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word("post_rst", 32'h00010000, 16'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/load_module.md
Name: load_module

Overview:
- DEC-TED (double-error-correct, triple-error-detect) checker for 32-bit words on the load path; sits between memory read data and the register-file writeback.
- Takes a 32-bit data word and its 16-bit stored check field.
- Corrects up to two flipped bits and flags three flipped bits.
- Outputs are registered: one cycle of latency.

Parameters:
- DATA_W, 32, data width (fixed by the code construction; not meant to be overridden).
- PAR_W, 16, check field width; only bits [12:0] are used.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- data  input  32  received data word
- parity  input  16  received check bits
- corrected_data  output  32  corrected data, registered
- triple_error  output  1  uncorrectable-error flag, registered

Behaviour:
- Code: extended binary BCH over GF(2^6), primitive polynomial x^6+x+1, α = 0b000010.
- Codeword of 45 bits:
  - data[i] occupies position j = i+1 (j = 1..32).
  - parity[k] for k = 0..12 occupies position j = 33+k (j = 33..45).
  - parity[15:13] are ignored entirely.
- Column of position j: h(j) = {P=1, α^(3j) (6b), α^j (6b)}, 13 bits. Bit 12 = overall parity; bits 11:6 = S3 part; bits 5:0 = S1 part.
- Syndrome S = XOR of h(j) over all positions j whose received bit is 1. Split S into P (bit 12), S3 and S1.
- Valid codewords give S = 0; the all-zero word is valid. Encoding is done by the store-side encoder and is out of scope here.
- Classification, all combinational, then registered:
  - S == 0: no error; corrected = data.
  - P == 1 and S == h(j) for exactly one j: single error. If j ≤ 32, invert data[j-1]; if j is a parity position, pass data unchanged.
  - P == 0, S != 0 and S == h(a) XOR h(b) for some a < b: double error. Invert each data bit among a and b; parity positions need no action.
  - Anything else (P == 1 with no single match, or P == 0 with no pair match): triple_error = 1 and corrected_data = raw data, uncorrected. This also covers 4+ error patterns.
- Minimum distance 6 guarantees the single and pair matches are unique, and that any weight-3 pattern never aliases to a single or a pair.
- Timing: inputs sampled at each rising clk edge; outputs valid after that edge. Latency 1, throughput 1 word per cycle. No handshake; a new word is accepted every cycle.
- Reset: rst_n low asynchronously forces corrected_data = 0 and triple_error = 0. They hold until the first rising edge after release. Reset mid-stream discards the in-flight result.
- The pair search is a static loop over 45·44/2 = 990 pairs. Implement it as a parallel compare with an OR-reduced one-hot flip mask, not a priority chain.

Decomposition:
- Package dected_pkg holds:
  - GF(64) constants: polynomial, α^k table for k = 0..62;
  - the function h(j);
  - constants NUM_POS = 45, DATA_W = 32, CHK_W = 13;
  - syndrome type typedef (13b).
- One sub-module, dected_syndrome: combinational; data + parity[12:0] -> 13-bit S.
- load_module does classification, flip-mask generation and the output registers.

Test Plan:
- Reset: rst_n = 0 with any inputs -> corrected_data = 0x00000000, triple_error = 0 immediately; both hold through release.
- Single: data = 0x00000001, 0x00000002, 0x00000004 (parity = 0x0000) -> corrected_data = 0x00000000, triple_error = 0, one cycle after each apply.
- Double: data = 0x00000005, then 0x00000003 (parity = 0x0000) -> corrected_data = 0x00000000, triple_error = 0.
- Triple: data = 0x00000007, parity = 0x0000 -> triple_error = 1, corrected_data = 0x00000007.
- Parity-field errors: data = 0, parity = 0x0001 -> corrected 0, no flag. parity = 0x0003 -> corrected 0, no flag. parity = 0xE000 -> corrected 0, no flag (ignored bits).
- Back-to-back mix: apply clean 0, then 0x80000001, then 0x00000007 on consecutive cycles -> outputs 0/0, 0/0, 0x7/1 on the three following cycles.
